// File: rtl/uab_rv_mem_loader.sv
`default_nettype none
// uab_rv_mem_loader -- Avalon-MM master that bulk loads/dumps the 64-bit on-chip RAM
// from/to a valid/ready word stream.  Revision 1.0

module uab_rv_mem_loader #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                mode,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     word_count,
  output logic                busy,
  output logic                done,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [ADDR_W-1:0]   avm_address,
  output logic [DATA_W/8-1:0] avm_byteenable,
  output logic                avm_chipselect,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  output logic                avm_clken,
  input  logic [DATA_W-1:0]   avm_readdata
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_LOAD_LAST = 3'd2,
    S_RD_ADDR   = 3'd3,
    S_RD_DATA   = 3'd4,
    S_RD_HOLD   = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  state_t              r_state,     w_state_nxt;
  logic [ADDR_W-1:0]   r_addr,      w_addr_nxt;
  logic [ADDR_W:0]     r_rem,       w_rem_nxt;
  logic                r_busy,      w_busy_nxt;
  logic                r_done,      w_done_nxt;
  logic                r_in_ready,  w_in_ready_nxt;
  logic                r_out_valid, w_out_valid_nxt;
  logic [DATA_W-1:0]   r_out_data,  w_out_data_nxt;
  logic                r_cs,        w_cs_nxt;
  logic                r_wr,        w_wr_nxt;
  logic [ADDR_W-1:0]   r_address,   w_address_nxt;
  logic [DATA_W-1:0]   r_wdata,     w_wdata_nxt;
  logic [BE_W-1:0]     r_be;
  logic                r_clken;

  always_comb begin
    w_state_nxt     = r_state;
    w_addr_nxt      = r_addr;
    w_rem_nxt       = r_rem;
    w_busy_nxt      = r_busy;
    w_done_nxt      = 1'b0;
    w_in_ready_nxt  = r_in_ready;
    w_out_valid_nxt = r_out_valid;
    w_out_data_nxt  = r_out_data;
    w_cs_nxt        = 1'b0;
    w_wr_nxt        = 1'b0;
    w_address_nxt   = r_address;
    w_wdata_nxt     = r_wdata;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_addr_nxt = base_addr;
          w_rem_nxt  = word_count;
          if (word_count == '0) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_DONE;
          end else if (!mode) begin
            w_busy_nxt     = 1'b1;
            w_in_ready_nxt = 1'b1;
            w_state_nxt    = S_LOAD;
          end else begin
            // First read address goes out in the same cycle busy rises.
            w_busy_nxt    = 1'b1;
            w_cs_nxt      = 1'b1;
            w_address_nxt = base_addr;
            w_state_nxt   = S_RD_ADDR;
          end
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          w_cs_nxt      = 1'b1;
          w_wr_nxt      = 1'b1;
          w_address_nxt = r_addr;
          w_wdata_nxt   = in_data;
          w_addr_nxt    = r_addr + ADDR_W'(1);
          w_rem_nxt     = r_rem - (ADDR_W+1)'(1);
          if (r_rem == (ADDR_W+1)'(1)) begin
            w_in_ready_nxt = 1'b0;
            w_state_nxt    = S_LOAD_LAST;
          end
        end
      end
      S_LOAD_LAST: begin
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_DONE;
      end
      S_RD_ADDR: begin
        w_state_nxt = S_RD_DATA;
      end
      S_RD_DATA: begin
        w_out_data_nxt  = avm_readdata;
        w_out_valid_nxt = 1'b1;
        w_addr_nxt      = r_addr + ADDR_W'(1);
        w_rem_nxt       = r_rem - (ADDR_W+1)'(1);
        w_state_nxt     = S_RD_HOLD;
      end
      S_RD_HOLD: begin
        if (out_ready) begin
          w_out_valid_nxt = 1'b0;
          if (r_rem != '0) begin
            w_cs_nxt      = 1'b1;
            w_address_nxt = r_addr;
            w_state_nxt   = S_RD_ADDR;
          end else begin
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_rem       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_cs        <= 1'b0;
      r_wr        <= 1'b0;
      r_address   <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_clken     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_addr      <= w_addr_nxt;
      r_rem       <= w_rem_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
      r_cs        <= w_cs_nxt;
      r_wr        <= w_wr_nxt;
      r_address   <= w_address_nxt;
      r_wdata     <= w_wdata_nxt;
      r_be        <= {BE_W{w_cs_nxt}};
      r_clken     <= 1'b1;
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign in_ready       = r_in_ready;
  assign out_valid      = r_out_valid;
  assign out_data       = r_out_data;
  assign avm_address    = r_address;
  assign avm_byteenable = r_be;
  assign avm_chipselect = r_cs;
  assign avm_write      = r_wr;
  assign avm_writedata  = r_wdata;
  assign avm_clken      = r_clken;

endmodule

`default_nettype wire

// File: doc/uab_rv_mem_loader.md
# uab_rv_mem_loader

Avalon-MM master that bulk-loads and reads back the 64-bit single-port on-chip RAM. It converts a valid/ready word stream into consecutive full-width RAM writes, or RAM reads into a valid/ready word stream. It sits beside the RISC-V core on the same RAM slave port. It gives the debug/boot path a way to preload or dump program memory without the CPU.

## Interface
Parameters:
- ADDR_W, 13, RAM word-address width; RAM depth is 2^ADDR_W words
- DATA_W, 64, RAM word width; byteenable width is DATA_W/8

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- mode  in  1  0 = load (stream→RAM), 1 = dump (RAM→stream); sampled with start
- base_addr  in  ADDR_W  first word address
- word_count  in  ADDR_W+1  number of words, 0..2^ADDR_W
- busy  out  1  high from cycle after accepted start until done
- done  out  1  one-cycle pulse at end of transfer
- in_valid / in_ready / in_data  in/out/in  1/1/DATA_W  load-mode source stream
- out_valid / out_ready / out_data  out/in/out  1/1/DATA_W  dump-mode sink stream
- avm_address  out  ADDR_W  RAM word address
- avm_byteenable  out  DATA_W/8  all-ones during any access, else 0
- avm_chipselect  out  1  access strobe
- avm_write  out  1  write qualifier
- avm_writedata  out  DATA_W  write data
- avm_clken  out  1  tied high while reset_n high
- avm_readdata  in  DATA_W  RAM read data, valid exactly 1 cycle after read address presented

## Operation
- All avm_* outputs, busy, done, in_ready, out_valid, out_data are registered. Reset value is 0 for all of them.
- FSM states: IDLE, LOAD, LOAD_LAST, RD_ADDR, RD_DATA, RD_HOLD, DONE.
- IDLE:
  - start with word_count=0 → DONE.
  - start with mode=0 → LOAD.
  - start with mode=1 → RD_ADDR.
  - Latch addr=base_addr, remaining=word_count.
- LOAD:
  - in_ready=1.
  - Each handshake registers chipselect=1, write=1, address=addr, writedata=in_data for the next cycle. Then addr+=1 and remaining-=1.
  - The handshake that brings remaining to 0 drops in_ready and moves to LOAD_LAST.
  - Cycles without a handshake drive chipselect=0, write=0.
- LOAD_LAST: issues the final write, then → DONE.
- RD_ADDR:
  - Drives chipselect=1, write=0, address=addr for one cycle, then → RD_DATA.
- RD_DATA:
  - Captures avm_readdata into out_data and sets out_valid=1.
  - Then addr+=1, remaining-=1 → RD_HOLD.
- RD_HOLD:
  - Waits for out_valid&out_ready.
  - On the handshake, out_valid clears. Go to RD_ADDR if remaining≠0, else DONE.
- DONE: done=1 for one cycle, busy=0, → IDLE.
- Address arithmetic is modulo 2^ADDR_W; base 8191 with count 2 accesses 8191 then 0.
- remaining is ADDR_W+1 bits, so count 8192 is legal.
- start while busy is ignored; mode/base/count changes while busy are ignored.
- In dump mode in_ready stays 0; in load mode out_valid stays 0.
- reset_n low at any time aborts immediately. No further access is driven and outputs return to reset values. A partially issued load leaves RAM contents as written so far.

## Timing
- start accepted at cycle T → busy=1 at T+1.
- Load: handshake at cycle N → write visible on avm_* in cycle N+1. Throughput is 1 word/cycle with in_valid held high.
- Load with count n and continuous valid: first write at T+2, last write at T+n+1, done at T+n+2.
- Dump: read address at cycle N → data captured at end of N+1 → out_valid=1 at N+2. The next read address comes the cycle after the out handshake. Throughput is 1 word per 3 cycles with out_ready held high.
- count=0: done at T+1, busy never asserted, no RAM access.

## Test plan
- Load 4 words 0x1111…1111..0x4444…4444 at base 0x0010, in_valid constant → writes to 0x0010..0x0013 on 4 consecutive cycles, byteenable=0xFF, done at T+6.
- Dump the same 4 words with out_ready=1 → out_data sequence 0x1111…1111..0x4444…4444, reads 3 cycles apart, done once.
- Wrap: load 2 words at base 0x1FFF, then dump 2 → accesses 0x1FFF then 0x0000, data matches.
- Backpressure: dump with out_ready low 5 cycles per word → out_data stable while out_valid high, no extra reads issued. In load mode, toggle in_valid → a write occurs only on handshake cycles.
- Edge cases: start with count=0 → single done pulse, chipselect never high. start during busy → ignored.
- reset_n low mid-load after 2 of 8 words → all outputs 0 immediately. After release the block returns to IDLE, and a new start loads correctly.
